// File: rtl/xor_rmw_issue.sv
// xor_rmw_issue: pipelined per-lane XOR read-modify-write issue with full-table clear.
// Define XOR_RMW_FWD_EN to add the write history that forwards not-yet-visible results.
module xor_rmw_issue #(
   parameter int NUM_MUL     = 4,
   parameter int INDEX_WIDTH = 12,
   parameter int DATA_WIDTH  = 64,
   parameter int RD_LAT      = 2,
   parameter int FWD_DEPTH   = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [INDEX_WIDTH-1:0]        in_index,
   input  logic [NUM_MUL-1:0]            in_mask,
   input  logic [NUM_MUL*DATA_WIDTH-1:0] in_data,
   output logic [INDEX_WIDTH-1:0]        rd_index,
   input  logic [NUM_MUL*DATA_WIDTH-1:0] rd_out_update,
   output logic                          write_reg_0_valid,
   output logic [INDEX_WIDTH-1:0]        write_reg_0_index,
   output logic [NUM_MUL*DATA_WIDTH-1:0] write_reg_11_xor,
   output logic [NUM_MUL-1:0]            arbiter_result,
   input  logic                          clear_start,
   output logic                          clear_done,
   output logic [31:0]                   op_count
);

   localparam int W  = NUM_MUL * DATA_WIDTH;
   localparam int NS = RD_LAT + 1;
   localparam logic [15:0] WAIT_LAST = 16'(RD_LAT + 3);

   if (RD_LAT < 1) begin : g_bad_lat
      $error("xor_rmw_issue: RD_LAT must be >= 1");
   end
   if (FWD_DEPTH < RD_LAT + 4) begin : g_bad_depth
      $error("xor_rmw_issue: FWD_DEPTH must be >= RD_LAT+4");
   end

   typedef enum logic [1:0] {
      RUN,
      DRAIN_PRE,
      CLEAR,
      DRAIN_POST
   } state_t;

   state_t                 state, state_nx;
   logic [INDEX_WIDTH-1:0] clr_idx, clr_idx_nx;
   logic [15:0]            wcnt, wcnt_nx;
   logic                   done_nx;

   logic                   accept;
   logic                   clr_issue;
   logic                   pipe_busy;

   // Stage k holds an op after the k-th edge following its issue.
   logic                   st_v   [NS];
   logic                   st_c   [NS];
   logic [INDEX_WIDTH-1:0] st_idx [NS];
   logic [NUM_MUL-1:0]     st_m   [NS];
   logic [W-1:0]           st_d   [NS];

   logic [W-1:0]           old;
   logic [W-1:0]           nw;

   assign in_ready  = (state == RUN);
   assign accept    = in_valid && in_ready;
   assign clr_issue = (state == CLEAR);

   assign write_reg_0_valid = st_v[RD_LAT-1];
   assign write_reg_0_index = st_v[RD_LAT-1] ? st_idx[RD_LAT-1] : '0;

   always_comb begin
      pipe_busy = 1'b0;
      for (int k = 0; k < NS; k++) begin
         pipe_busy = pipe_busy | st_v[k];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NS; k++) begin
            st_v[k]   <= 1'b0;
            st_c[k]   <= 1'b0;
            st_idx[k] <= '0;
            st_m[k]   <= '0;
            st_d[k]   <= '0;
         end
      end else begin
         st_v[0]   <= accept | clr_issue;
         st_c[0]   <= clr_issue;
         st_idx[0] <= clr_issue ? clr_idx : in_index;
         st_m[0]   <= clr_issue ? '1 : in_mask;
         st_d[0]   <= clr_issue ? '0 : in_data;
         for (int k = 1; k < NS; k++) begin
            st_v[k]   <= st_v[k-1];
            st_c[k]   <= st_c[k-1];
            st_idx[k] <= st_idx[k-1];
            st_m[k]   <= st_m[k-1];
            st_d[k]   <= st_d[k-1];
         end
      end
   end

`ifdef XOR_RMW_FWD_EN
   logic                   h_v   [FWD_DEPTH];
   logic [INDEX_WIDTH-1:0] h_idx [FWD_DEPTH];
   logic [NUM_MUL-1:0]     h_m   [FWD_DEPTH];
   logic [W-1:0]           h_d   [FWD_DEPTH];

   // Entry 0 is the youngest write; it is the one on the output right now.
   always_ff @(posedge clk) begin
      if (reset || done_nx) begin
         for (int h = 0; h < FWD_DEPTH; h++) begin
            h_v[h]   <= 1'b0;
            h_idx[h] <= '0;
            h_m[h]   <= '0;
            h_d[h]   <= '0;
         end
      end else if (st_v[RD_LAT]) begin
         for (int h = 1; h < FWD_DEPTH; h++) begin
            h_v[h]   <= h_v[h-1];
            h_idx[h] <= h_idx[h-1];
            h_m[h]   <= h_m[h-1];
            h_d[h]   <= h_d[h-1];
         end
         h_v[0]   <= 1'b1;
         h_idx[0] <= st_idx[RD_LAT];
         h_m[0]   <= st_m[RD_LAT];
         h_d[0]   <= nw;
      end
   end

   always_comb begin
      old = rd_out_update;
      for (int h = FWD_DEPTH - 1; h >= 0; h--) begin
         for (int i = 0; i < NUM_MUL; i++) begin
            if (h_v[h] && h_m[h][i] && h_idx[h] == st_idx[RD_LAT]) begin
               old[i*DATA_WIDTH +: DATA_WIDTH] = h_d[h][i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end
`else
   always_comb begin
      old = rd_out_update;
   end
`endif

   always_comb begin
      nw = '0;
      for (int i = 0; i < NUM_MUL; i++) begin
         if (st_m[RD_LAT][i] && !st_c[RD_LAT]) begin
            nw[i*DATA_WIDTH +: DATA_WIDTH] = old[i*DATA_WIDTH +: DATA_WIDTH]
                                           ^ st_d[RD_LAT][i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         write_reg_11_xor <= '0;
         arbiter_result   <= '0;
      end else if (st_v[RD_LAT]) begin
         write_reg_11_xor <= nw;
         arbiter_result   <= st_m[RD_LAT];
      end else begin
         write_reg_11_xor <= '0;
         arbiter_result   <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_index <= '0;
         op_count <= '0;
      end else if (accept) begin
         rd_index <= in_index;
         op_count <= op_count + 32'd1;
      end
   end

   always_comb begin
      state_nx   = state;
      clr_idx_nx = clr_idx;
      wcnt_nx    = wcnt;
      done_nx    = 1'b0;
      unique case (state)
         RUN: begin
            if (clear_start) begin
               state_nx = DRAIN_PRE;
            end
         end
         DRAIN_PRE: begin
            clr_idx_nx = '0;
            if (!pipe_busy) begin
               state_nx = CLEAR;
            end
         end
         CLEAR: begin
            clr_idx_nx = clr_idx + 1'b1;
            if (clr_idx == '1) begin
               state_nx = DRAIN_POST;
               wcnt_nx  = '0;
            end
         end
         DRAIN_POST: begin
            wcnt_nx = wcnt + 16'd1;
            if (wcnt == WAIT_LAST) begin
               state_nx = RUN;
               done_nx  = 1'b1;
            end
         end
         default: state_nx = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= RUN;
         clr_idx    <= '0;
         wcnt       <= '0;
         clear_done <= 1'b0;
      end else begin
         state      <= state_nx;
         clr_idx    <= clr_idx_nx;
         wcnt       <= wcnt_nx;
         clear_done <= done_nx;
      end
   end

endmodule

// File: doc/xor_rmw_issue.md
XOR_RMW_ISSUE -- requirements
Module: xor_rmw_issue

Interface
REQ-001 SHALL have parameter NUM_MUL, default 4, number of lanes.
REQ-002 SHALL have parameter INDEX_WIDTH, default 12, table address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, lane word width.
REQ-004 SHALL have parameter RD_LAT, default 2, cycles from rd_index to valid rd_out_update; legal values are RD_LAT >= 1.
REQ-005 SHALL have parameter FWD_DEPTH, default 8, number of forwarding history entries; legal values are FWD_DEPTH >= RD_LAT+4.
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port in_valid  in  1  request valid.
REQ-009 SHALL have port in_ready  out  1  request accepted when in_valid and in_ready are both high at a clock edge.
REQ-010 SHALL have port in_index  in  INDEX_WIDTH  target index.
REQ-011 SHALL have port in_mask  in  NUM_MUL  per-lane update enable.
REQ-012 SHALL have port in_data  in  NUM_MUL*DATA_WIDTH  per-lane XOR operand.
REQ-013 SHALL have port rd_index  out  INDEX_WIDTH  table read address.
REQ-014 SHALL have port rd_out_update  in  NUM_MUL*DATA_WIDTH  table read data.
REQ-015 SHALL have port write_reg_0_valid  out  1  early write-valid tag.
REQ-016 SHALL have port write_reg_0_index  out  INDEX_WIDTH  early write-index tag.
REQ-017 SHALL have port write_reg_11_xor  out  NUM_MUL*DATA_WIDTH  write data.
REQ-018 SHALL have port arbiter_result  out  NUM_MUL  per-lane write enable.
REQ-019 SHALL have port clear_start  in  1  single-cycle pulse requesting a full-table zero.
REQ-020 SHALL have port clear_done  out  1  single-cycle pulse when the clear completes.
REQ-021 SHALL have port op_count  out  32  number of accepted requests, wrapping.

Function
REQ-022 For a request accepted at edge E0, rd_index SHALL equal in_index from after E0; rd_out_update SHALL be sampled at E(RD_LAT+1).
REQ-023 For each lane i, new[i] SHALL be old[i] XOR in_data[i] when in_mask[i]=1; the module SHALL register new[i] and in_mask onto write_reg_11_xor and arbiter_result after E(RD_LAT+1); lanes with a mask bit of 0 SHALL drive 0 and SHALL NOT be written.
REQ-024 write_reg_0_valid and write_reg_0_index SHALL be driven exactly 2 cycles before the matching write_reg_11_xor, i.e. after E(RD_LAT-1).
REQ-025 The datapath SHALL be fully pipelined: in RUN it SHALL accept 1 request/cycle with in_ready=1; no output SHALL depend combinationally on in_valid.
REQ-026 Forwarding history: each issued write SHALL push {index, mask, new data} into a FWD_DEPTH shift history.
REQ-027 old[i] SHALL come from the youngest history entry, or in-pipe older op, with matching index and mask[i]=1; otherwise old[i] SHALL come from rd_out_update lane i.
REQ-028 The FSM states SHALL be RUN, DRAIN_PRE, CLEAR, DRAIN_POST.
REQ-029 RUN SHALL go to DRAIN_PRE on clear_start; in_ready SHALL be 0 in every state other than RUN, starting the cycle after clear_start.
REQ-030 DRAIN_PRE SHALL go to CLEAR once no request remains in the pipeline.
REQ-031 CLEAR SHALL issue one write per cycle for indices 0 through 2^INDEX_WIDTH-1, with data all zero and arbiter_result all ones, honouring REQ-024 timing; CLEAR SHALL NOT assert rd_index activity semantics.
REQ-032 After the last index, CLEAR SHALL go to DRAIN_POST; DRAIN_POST SHALL wait RD_LAT+4 cycles, invalidate the history, pulse clear_done, and return to RUN.
REQ-033 clear_start SHALL be ignored outside RUN.
REQ-034 A clear_start asserted in the same cycle as an accepted request SHALL let that request complete before CLEAR begins.
REQ-035 op_count SHALL increment per accepted request and wrap at 2^32; clear SHALL NOT change it.

Reset
REQ-036 On reset, the state SHALL be RUN, all valid flags and history entries SHALL be cleared, op_count, write_reg_0_valid, arbiter_result, write_reg_11_xor, write_reg_0_index, rd_index and clear_done SHALL be 0, and in_ready SHALL be 1 after reset deasserts.
REQ-037 Reset mid-operation, including during CLEAR, SHALL abort all in-flight ops with no further writes issued; table contents SHALL be left unchanged.

Configuration
REQ-038 With macro XOR_RMW_FWD_EN defined, REQ-026 and REQ-027 forwarding SHALL be present; without it, the history SHALL be omitted and old[i] SHALL always be rd_out_update lane i, so back-to-back same-index updates read stale data.

Verification
REQ-039 Single op: with index 5 holding 0 in all lanes, mask 4'b0001 and data lane0 0xA5 -> write_reg_0 index 5 after E1, then write_reg_11_xor lane0 0xA5 with arbiter_result 0001 after E3.
REQ-040 Back-to-back: three consecutive ops to index 7, lane0 data 0x1, 0x2, 0x4, with XOR_RMW_FWD_EN defined -> written values 0x1, 0x3, 0x7.
REQ-041 Mixed masks: ops to index 9 with masks 0011 then 0110 -> the second op forwards lane1 only, and lanes 2 and 0 behave per REQ-023 and REQ-027.
REQ-042 Clear with 3 ops in flight -> those 3 writes first, then 4096 zero writes at indices 0..4095, then clear_done one pulse, with in_ready low throughout.
REQ-043 Reset asserted at CLEAR index 100 -> no writes after reset, state RUN, op_count 0.
